// File: rtl/sb_master_ctrl.sv
`default_nettype none
// sb_master_ctrl: single-outstanding system-bus initiator with a wait-state
// handshake, a bus timeout and a valid/ready response channel.
module sb_master_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        req_o,
  output logic        write_enable_o,
  output logic [31:0] addr_o,
  output logic [31:0] write_data_o,
  input  logic [31:0] read_data_i,
  input  logic        ready_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] count;
  logic       cmd_we;
  logic       timeout_hit;

  // Counter value in the final allowed request cycle.
  assign timeout_hit = (count == TIMEOUT_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    cmd_ready_o    = 1'b0;
    req_o          = 1'b0;
    write_enable_o = 1'b0;
    rsp_valid_o    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          state_next = BUS;
        end
      end
      BUS: begin
        req_o          = 1'b1;
        write_enable_o = cmd_we;
        if (ready_i || timeout_hit) begin
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Command latch, timeout counter and response capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count        <= 8'd0;
      cmd_we       <= 1'b0;
      addr_o       <= 32'd0;
      write_data_o <= 32'd0;
      rsp_data_o   <= 32'd0;
      rsp_err_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            cmd_we       <= cmd_we_i;
            addr_o       <= cmd_addr_i;
            write_data_o <= cmd_wdata_i;
            count        <= 8'd0;
          end
        end
        BUS: begin
          count <= count + 8'd1;
          // A responder completing in the timeout cycle still wins.
          if (ready_i) begin
            rsp_data_o <= cmd_we ? 32'd0 : read_data_i;
            rsp_err_o  <= 1'b0;
          end else if (timeout_hit) begin
            rsp_data_o <= 32'd0;
            rsp_err_o  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sb_master_ctrl.sv
`default_nettype none
// tb_sb_master_ctrl: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model of the initiator.
module tb_sb_master_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [31:0] cmd_addr_i = 32'd0;
  logic [31:0] cmd_wdata_i = 32'd0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_data_o;
  logic        rsp_err_o;
  logic        req_o;
  logic        write_enable_o;
  logic [31:0] addr_o;
  logic [31:0] write_data_o;
  logic [31:0] read_data_i = 32'd0;
  logic        ready_i = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  sb_master_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_we_i       (cmd_we_i),
    .cmd_addr_i     (cmd_addr_i),
    .cmd_wdata_i    (cmd_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_data_o     (rsp_data_o),
    .rsp_err_o      (rsp_err_o),
    .req_o          (req_o),
    .write_enable_o (write_enable_o),
    .addr_o         (addr_o),
    .write_data_o   (write_data_o),
    .read_data_i    (read_data_i),
    .ready_i        (ready_i)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Transaction-level model: one command in flight, counted request cycles,
  // and a pending response record.
  bit          m_busy = 0;
  bit          m_done = 0;
  bit          m_we = 0;
  logic [31:0] m_addr = 0;
  logic [31:0] m_wdata = 0;
  logic [31:0] m_data = 0;
  bit          m_err = 0;
  int          m_cycles = 0;

  always @(posedge clk) begin
    if (rst_i) begin
      m_busy = 0; m_done = 0; m_we = 0; m_addr = 0; m_wdata = 0;
      m_data = 0; m_err = 0; m_cycles = 0;
    end else if (!m_busy) begin
      if (cmd_valid_i) begin
        m_busy = 1; m_done = 0; m_cycles = 0;
        m_we = cmd_we_i; m_addr = cmd_addr_i; m_wdata = cmd_wdata_i;
      end
    end else if (!m_done) begin
      m_cycles++;
      if (ready_i) begin
        m_done = 1; m_err = 0;
        m_data = m_we ? 32'd0 : read_data_i;
      end else if (m_cycles == TIMEOUT) begin
        m_done = 1; m_err = 1; m_data = 32'd0;
      end
    end else if (rsp_ready_i) begin
      m_busy = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready", 32'(cmd_ready_o), 32'(!m_busy));
      chk("req", 32'(req_o), 32'(m_busy && !m_done));
      chk("write_enable", 32'(write_enable_o), 32'(m_busy && !m_done && m_we));
      chk("addr", addr_o, m_addr);
      chk("write_data", write_data_o, m_wdata);
      chk("rsp_valid", 32'(rsp_valid_o), 32'(m_busy && m_done));
      if (m_busy && m_done) begin
        chk("rsp_data", rsp_data_o, m_data);
        chk("rsp_err", 32'(rsp_err_o), 32'(m_err));
      end
    end
  end

  // waits < 0: responder never answers.
  task automatic run_cmd(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input int waits, input logic [31:0] rd,
                         output int reqs, output logic [31:0] data, output logic err);
    int n;
    @(negedge clk);
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = a; cmd_wdata_i = d;
    ready_i = 1'b0; rsp_ready_i = 1'b0;
    n = 0;
    while (!cmd_ready_o && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid_i = 1'b0;
    reqs = 0; n = 0;
    while (!rsp_valid_o && n < 300) begin
      if (req_o) begin
        reqs++;
        ready_i = (waits >= 0) && (reqs == waits + 1);
        read_data_i = ready_i ? rd : $urandom;
      end
      @(negedge clk);
      ready_i = 1'b0;
      n++;
    end
    if (!rsp_valid_o) chk("rsp_wait_bound", 32'(rsp_valid_o), 32'd1);
    data = rsp_data_o; err = rsp_err_o;
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          reqs;
    logic [31:0] data;
    logic        err;

    // Reset with a command already offered.
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 32'h100;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_req", 32'(req_o), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_addr", addr_o, 32'd0);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_rsp_data", rsp_data_o, 32'd0);
    rst_i = 1'b0;
    @(negedge clk);
    chk("post_rst_req", 32'(req_o), 32'd1);
    chk("post_rst_addr", addr_o, 32'h100);
    cmd_valid_i = 1'b0; ready_i = 1'b1; read_data_i = 32'h1234_5678;
    @(negedge clk);
    ready_i = 1'b0;
    chk("post_rst_rsp", rsp_data_o, 32'h1234_5678);
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;

    run_cmd(1'b1, 32'h24, 32'hA5, 0, 32'hFFFF_FFFF, reqs, data, err);
    chk("zw_reqs", 32'(reqs), 32'd1);
    chk("zw_data", data, 32'd0);
    chk("zw_err", 32'(err), 32'd0);

    run_cmd(1'b0, 32'h4, 32'h0, 3, 32'hDEAD_BEEF, reqs, data, err);
    chk("rd_reqs", 32'(reqs), 32'd4);
    chk("rd_data", data, 32'hDEAD_BEEF);
    chk("rd_err", 32'(err), 32'd0);

    run_cmd(1'b0, 32'h8, 32'h0, -1, 32'h0, reqs, data, err);
    chk("to_reqs", 32'(reqs), 32'd16);
    chk("to_data", data, 32'd0);
    chk("to_err", 32'(err), 32'd1);

    run_cmd(1'b0, 32'hC, 32'h0, 15, 32'h0BAD_F00D, reqs, data, err);
    chk("last_reqs", 32'(reqs), 32'd16);
    chk("last_data", data, 32'h0BAD_F00D);
    chk("last_err", 32'(err), 32'd0);

    // Response backpressure with a second command waiting.
    @(negedge clk);
    cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_addr_i = 32'h30; cmd_wdata_i = 32'h5A;
    ready_i = 1'b1;
    @(negedge clk);
    cmd_we_i = 1'b0; cmd_addr_i = 32'h40; cmd_wdata_i = 32'h77;
    @(negedge clk);
    ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_cmd_ready", 32'(cmd_ready_o), 32'd0);
      chk("bp_rsp_valid", 32'(rsp_valid_o), 32'd1);
      chk("bp_rsp_data", rsp_data_o, 32'd0);
      @(negedge clk);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    chk("bp_idle_req", 32'(req_o), 32'd0);
    chk("bp_idle_cmd_ready", 32'(cmd_ready_o), 32'd1);
    @(negedge clk);
    chk("bp_second_req", 32'(req_o), 32'd1);
    chk("bp_second_addr", addr_o, 32'h40);
    cmd_valid_i = 1'b0; ready_i = 1'b1; read_data_i = 32'hCAFE_0001;
    @(negedge clk);
    ready_i = 1'b0;
    chk("bp_second_data", rsp_data_o, 32'hCAFE_0001);
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;

    // Reset in the second bus cycle.
    cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_addr_i = 32'h50; cmd_wdata_i = 32'h11;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    @(negedge clk);
    chk("mid_req_before", 32'(req_o), 32'd1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("mid_req_after", 32'(req_o), 32'd0);
    chk("mid_rsp_valid", 32'(rsp_valid_o), 32'd0);
    run_cmd(1'b0, 32'h60, 32'h0, 2, 32'h600D_0060, reqs, data, err);
    chk("mid_next_reqs", 32'(reqs), 32'd3);
    chk("mid_next_data", data, 32'h600D_0060);

    // Randomized traffic, including sporadic resets and timeouts.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst_i       = ($urandom_range(0, 299) == 0);
      cmd_valid_i = ($urandom_range(0, 3) != 0);
      cmd_we_i    = 1'($urandom);
      cmd_addr_i  = $urandom;
      cmd_wdata_i = $urandom;
      ready_i     = ($urandom_range(0, 5) == 0);
      read_data_i = $urandom;
      rsp_ready_i = ($urandom_range(0, 2) == 0);
    end
    @(negedge clk);
    rst_i = 1'b0; cmd_valid_i = 1'b0; ready_i = 1'b0; rsp_ready_i = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
